sevseg_scan_ctrl: RTL and testbench

SEVSEG_SCAN_CTRL -- requirements
Module: sevseg_scan_ctrl

---
 rtl/sevseg_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_sevseg_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, frame-shadowed
// data with leading-zero blanking, and PWM brightness gating on the anodes.
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 10000,
    parameter int PWM_BITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] disp_data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_lz_i,
    input  logic [PWM_BITS-1:0]     brightness_i,
    output logic [7:0]              sev_cathode_o,
    output logic [NUM_DIGITS-1:0]   sev_anode_o,
    output logic                    frame_done_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre_cnt;
    logic [IDX_W-1:0]        idx;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic                    en_q;
    logic [4*NUM_DIGITS-1:0] shd_data;
    logic [NUM_DIGITS-1:0]   shd_dp;
    logic                    shd_blz;

    logic                    tc, frame_end, snap, lit, lead;
    logic [4*NUM_DIGITS-1:0] src_data;
    logic [NUM_DIGITS-1:0]   src_dp, blank;
    logic                    src_blz;
    logic [3:0]              nib;
    logic [7:0]              cath_nxt;
    logic [NUM_DIGITS-1:0]   anode_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    assign tc        = (pre_cnt == PRE_MAX);
    assign frame_end = tc && (idx == IDX_MAX);
    assign snap      = en_i && (!en_q || frame_end);

    // On the first enabled cycle the shadows are still being loaded, so decode
    // straight from the inputs; afterwards only the frame snapshot is used.
    assign src_data = en_q ? shd_data : disp_data_i;
    assign src_dp   = en_q ? shd_dp   : dp_i;
    assign src_blz  = en_q ? shd_blz  : blank_lz_i;

    always_comb begin
        lead  = src_blz;
        blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead && src_data[4*k +: 4] == 4'h0) blank[k] = 1'b1;
            else                                     lead     = 1'b0;
        end
    end

    always_comb begin
        if (brightness_i == '1)      lit = 1'b1;
        else if (brightness_i == '0) lit = 1'b0;
        else                         lit = (pwm_cnt < brightness_i);
    end

    always_comb begin
        nib       = src_data[{idx, 2'b00} +: 4];
        cath_nxt  = 8'hFF;
        anode_nxt = '1;
        if (lit) begin
            cath_nxt       = {~src_dp[idx], blank[idx] ? 7'h7F : seg7(nib)};
            anode_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt       <= '0;
            idx           <= '0;
            pwm_cnt       <= '0;
            en_q          <= 1'b0;
            shd_data      <= '0;
            shd_dp        <= '0;
            shd_blz       <= 1'b0;
            sev_cathode_o <= 8'hFF;
            sev_anode_o   <= '1;
            frame_done_o  <= 1'b0;
        end else if (!en_i) begin
            pre_cnt       <= '0;
            idx           <= '0;
            pwm_cnt       <= '0;
            en_q          <= 1'b0;
            sev_cathode_o <= 8'hFF;
            sev_anode_o   <= '1;
            frame_done_o  <= 1'b0;
        end else begin
            pre_cnt       <= tc ? '0 : pre_cnt + 1'b1;
            if (tc) idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            pwm_cnt       <= pwm_cnt + 1'b1;
            en_q          <= 1'b1;
            sev_cathode_o <= cath_nxt;
            sev_anode_o   <= anode_nxt;
            frame_done_o  <= frame_end;
            if (snap) begin
                shd_data <= disp_data_i;
                shd_dp   <= dp_i;
                shd_blz  <= blank_lz_i;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Bench for sevseg_scan_ctrl: time-since-enable reference model checked every
// cycle, plus literal pins for the key scan/blanking/brightness scenarios.
module tb_sevseg_scan_ctrl;
    localparam int N = 4, DIV = 4, PB = 2, P = N * DIV;

    logic          clk = 1'b0;
    logic          rst, en, blz;
    logic [15:0]   data;
    logic [3:0]    dp;
    logic [PB-1:0] bright;
    logic [7:0]    cath;
    logic [3:0]    anode;
    logic          fd;

    int tests = 0, fails = 0;

    sevseg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .PWM_BITS(PB)) dut (
        .clk(clk), .rst(rst), .en_i(en), .disp_data_i(data), .dp_i(dp),
        .blank_lz_i(blz), .brightness_i(bright), .sev_cathode_o(cath),
        .sev_anode_o(anode), .frame_done_o(fd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Active-low {dp,g,f,e,d,c,b,a} hex glyphs with dp off.
    logic [7:0] seg_tab [16];
    initial seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model: t counts enabled cycles since enable/reset; digit, PWM phase and frame
    // position all derive from t by plain division.
    int         t = 0;
    bit         en_prev = 0;
    logic [15:0] sd = '0;
    logic [3:0]  sdp = '0;
    bit          sblz = 0;

    always @(posedge clk) begin
        logic        r, e, b;
        logic [15:0] d;
        logic [3:0]  dps, ea;
        logic [1:0]  br;
        logic [7:0]  ec;
        logic        efd, lit, blanked;
        int          dig, ph;
        r = rst; e = en; b = blz; d = data; dps = dp; br = bright;
        ec = 8'hFF; ea = 4'hF; efd = 1'b0;
        if (r) begin
            t = 0; en_prev = 0; sd = '0; sdp = '0; sblz = 0;
        end else if (!e) begin
            t = 0; en_prev = 0;
        end else begin
            if (!en_prev) begin sd = d; sdp = dps; sblz = b; end
            dig = (t / DIV) % N;
            ph  = t % (1 << PB);
            lit = (br == 2'b11) ? 1'b1 : (br == 2'b00) ? 1'b0 : (ph < int'(br));
            if (lit) begin
                ea      = ~(4'b0001 << dig);
                blanked = sblz && dig != 0 && ((sd >> (4 * dig)) == 16'h0);
                ec      = blanked ? 8'hFF : seg_tab[sd[dig*4 +: 4]];
                if (sdp[dig]) ec[7] = 1'b0;
            end
            efd = (t % P) == P - 1;
            if ((t % P) == P - 1) begin sd = d; sdp = dps; sblz = b; end
            t++;
            en_prev = 1;
        end
        #1;
        if (!rst) begin
            chk("model_anode", 32'(anode), 32'(ea));
            chk("model_cathode", 32'(cath), 32'(ec));
            chk("model_frame_done", 32'(fd), 32'(efd));
            chk("one_anode_max", 32'($countones(~anode) <= 1), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; en = 1'b0; blz = 1'b0; data = '0; dp = '0; bright = 2'b11;
        cyc(3);
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_cathode", 32'(cath), 32'hFF);
        chk("reset_fd", 32'(fd), 32'h0);

        // 12AF at full brightness straight out of reset.
        rst = 1'b0; en = 1'b1; data = 16'h12AF;
        for (int k = 1; k <= 17; k++) begin
            cyc(1);
            if (k <= 4) begin
                chk("s1_d0_anode", 32'(anode), 32'hE);
                chk("s1_d0_cath", 32'(cath), 32'h8E);
            end
            if (k == 5)  chk("s1_d1_cath", 32'({anode, cath}), 32'hD88);
            if (k == 9)  chk("s1_d2_cath", 32'({anode, cath}), 32'hBA4);
            if (k == 13) chk("s1_d3_cath", 32'({anode, cath}), 32'h7F9);
            if (k == 15) chk("s1_fd_early", 32'(fd), 32'h0);
            if (k == 16) chk("s1_fd_pulse", 32'(fd), 32'h1);
            if (k == 17) chk("s1_fd_single", 32'(fd), 32'h0);
        end
        en = 1'b0;
        cyc(1);
        chk("dis_anode", 32'(anode), 32'hF);

        // Leading-zero blanking; 0000 loaded mid-frame applies from next frame.
        data = 16'h0050; blz = 1'b1; en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cyc(1);
            if (k == 10) data = 16'h0000;
            if (k == 1)  chk("lz_d0", 32'({anode, cath}), 32'hEC0);
            if (k == 5)  chk("lz_d1", 32'({anode, cath}), 32'hD92);
            if (k == 9)  chk("lz_d2", 32'({anode, cath}), 32'hBFF);
            if (k == 13) chk("lz_d3", 32'({anode, cath}), 32'h7FF);
            if (k == 17) chk("z_d0", 32'({anode, cath}), 32'hEC0);
            if (k == 21) chk("z_d1", 32'({anode, cath}), 32'hDFF);
        end
        en = 1'b0; blz = 1'b0;
        cyc(1);

        // No tearing: 2222 arrives at idx=1, still shows 1 until next frame.
        data = 16'h1111; en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cyc(1);
            if (k == 6)  data = 16'h2222;
            if (k == 9)  chk("tear_d2", 32'(cath), 32'hF9);
            if (k == 13) chk("tear_d3", 32'(cath), 32'hF9);
            if (k == 17) chk("tear_new", 32'(cath), 32'hA4);
        end
        en = 1'b0;  // dropped while idx=2
        cyc(1);
        chk("drop_off", 32'({anode, cath, 3'b000, fd}), 32'hFFF0);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("drop_no_fd", 32'(fd), 32'h0);
        end
        data = 16'h3333; en = 1'b1;
        cyc(1);
        chk("reen_d0", 32'({anode, cath}), 32'hEB0);

        // Brightness duty.
        bright = 2'b01;
        cyc(1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin cyc(1); if (anode != 4'hF) cnt++; end
        chk("duty_1of4", 32'(cnt), 32'd4);
        bright = 2'b00;
        cyc(1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin cyc(1); if (anode != 4'hF) cnt++; end
        chk("duty_zero", 32'(cnt), 32'd0);

        // Asynchronous reset mid-cycle.
        bright = 2'b11;
        cyc(6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_rst", 32'({anode, cath, 3'b000, fd}), 32'hFFF0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rst_restart", 32'({anode, cath}), 32'hEB0);

        // Randomised traffic, reference model checks every cycle.
        for (int k = 0; k < 900; k++) begin
            int r;
            cyc(1);
            if (rst) rst = 1'b0;
            r = $urandom_range(0, 999);
            if (r < 25)       en = ~en;
            else if (r < 30)  rst = 1'b1;
            else if (r < 150) data = 16'($urandom);
            else if (r < 200) dp = 4'($urandom);
            else if (r < 240) blz = 1'($urandom);
            else if (r < 290) bright = 2'($urandom);
            else if (r < 330) data = 16'($urandom_range(0, 3) << (4 * $urandom_range(0, 3)));
        end
        rst = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
